// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = pipeline side (drives hazard inputs), slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int AWIDTH    = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 hc_i_id_ce;
  logic [AWIDTH-1:0]    hc_i_id_addr_rs1;
  logic [AWIDTH-1:0]    hc_i_id_addr_rs2;
  logic                 hc_i_id_use_rs1;
  logic                 hc_i_id_use_rs2;
  logic                 hc_i_ex_ce;
  logic                 hc_i_ex_load;
  logic [AWIDTH-1:0]    hc_i_ex_addr_rd;
  logic                 hc_i_ex_change_pc;
  logic                 hc_i_mem_req;
  logic                 hc_i_mem_ack;

  logic                 hc_o_if_stall;
  logic                 hc_o_id_stall;
  logic                 hc_o_ex_stall;
  logic                 hc_o_mem_stall;
  logic                 hc_o_if_flush;
  logic                 hc_o_id_flush;
  logic                 hc_o_ex_flush;
  logic                 hc_o_timeout;
  logic [CNT_WIDTH-1:0] hc_o_stall_cnt;
  logic [1:0]           hc_o_state;

  modport master (
    output hc_i_id_ce, hc_i_id_addr_rs1, hc_i_id_addr_rs2, hc_i_id_use_rs1,
           hc_i_id_use_rs2, hc_i_ex_ce, hc_i_ex_load, hc_i_ex_addr_rd,
           hc_i_ex_change_pc, hc_i_mem_req, hc_i_mem_ack,
    input  hc_o_if_stall, hc_o_id_stall, hc_o_ex_stall, hc_o_mem_stall,
           hc_o_if_flush, hc_o_id_flush, hc_o_ex_flush, hc_o_timeout,
           hc_o_stall_cnt, hc_o_state
  );

  modport slave (
    input  hc_i_id_ce, hc_i_id_addr_rs1, hc_i_id_addr_rs2, hc_i_id_use_rs1,
           hc_i_id_use_rs2, hc_i_ex_ce, hc_i_ex_load, hc_i_ex_addr_rd,
           hc_i_ex_change_pc, hc_i_mem_req, hc_i_mem_ack,
    output hc_o_if_stall, hc_o_id_stall, hc_o_ex_stall, hc_o_mem_stall,
           hc_o_if_flush, hc_o_id_flush, hc_o_ex_flush, hc_o_timeout,
           hc_o_stall_cnt, hc_o_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: load-use bubbles,
// execute-stage redirects, data-memory waits, timeout flag and stall counter.
module pipe_hazard_ctrl #(
  parameter int AWIDTH      = 5,
  parameter int FLUSH_LEN   = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 16
) (
  input logic               hc_clk,
  input logic               hc_rst,
  pipe_hazard_ctrl_if.slave hc
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam int FCW = $clog2(FLUSH_LEN + 1);
  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_LEN - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT   = WCW'(MEM_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [FCW-1:0]       cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use, mem_wait, rs1_hit, rs2_hit;
  logic [WCW-1:0] wait_inc;
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic if_flush, id_flush, ex_flush;

  assign rs1_hit  = hc.hc_i_id_use_rs1 && (hc.hc_i_id_addr_rs1 == hc.hc_i_ex_addr_rd);
  assign rs2_hit  = hc.hc_i_id_use_rs2 && (hc.hc_i_id_addr_rs2 == hc.hc_i_ex_addr_rd);
  assign load_use = hc.hc_i_id_ce && hc.hc_i_ex_ce && hc.hc_i_ex_load &&
                    (hc.hc_i_ex_addr_rd != '0) && (rs1_hit || rs2_hit);
  assign mem_wait = hc.hc_i_mem_req && !hc.hc_i_mem_ack;
  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WCW'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    mem_stall   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
          pending_d  = hc.hc_i_ex_change_pc;  // redirect deferred behind the memory stall
        end else if (hc.hc_i_ex_change_pc) begin
          {if_flush, id_flush} = 2'b11;
          if (FLUSH_LEN > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (load_use) begin
          {if_stall, id_stall, ex_flush} = 3'b111;
        end
      end

      ST_MEM_WAIT: begin
        if (!hc.hc_i_mem_ack) begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
          pending_d  = pending_q || hc.hc_i_ex_change_pc;
          wait_cnt_d = wait_inc;
          if (wait_inc >= WAIT_LIMIT) timeout_d = 1'b1;
        end else begin
          pending_d = 1'b0;
          if (pending_q || hc.hc_i_ex_change_pc) begin
            {if_flush, id_flush} = 2'b11;
            if (FLUSH_LEN > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = FLUSH_RELOAD;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_FLUSH: begin
        // ID holds a wrong-path instruction here, so load_use is not consulted.
        {if_flush, id_flush} = 2'b11;
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          pending_d  = 1'b1;
          wait_cnt_d = '0;
        end else if (hc.hc_i_ex_change_pc) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= FCW'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - FCW'(1);
        end
      end

      default: state_d = ST_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (if_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge hc_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (hc_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are silenced while reset is held so the pipeline is never frozen by stale state.
  assign hc.hc_o_if_stall  = if_stall  && !hc_rst;
  assign hc.hc_o_id_stall  = id_stall  && !hc_rst;
  assign hc.hc_o_ex_stall  = ex_stall  && !hc_rst;
  assign hc.hc_o_mem_stall = mem_stall && !hc_rst;
  assign hc.hc_o_if_flush  = if_flush  && !hc_rst;
  assign hc.hc_o_id_flush  = id_flush  && !hc_rst;
  assign hc.hc_o_ex_flush  = ex_flush  && !hc_rst;
  assign hc.hc_o_timeout   = timeout_q;
  assign hc.hc_o_stall_cnt = stall_cnt_q;
  assign hc.hc_o_state     = state_q;

endmodule
